// File: rtl/nios2_oci_dct_capture.sv
// nios2_oci_dct_capture: arm/capture/drain FIFO for {dct_count, dct_buffer} trace entries
module nios2_oci_dct_capture #(
   parameter int DCT_W = 30,
   parameter int CNT_W = 4,
   parameter int DEPTH = 16,
   parameter int OVERWRITE = 0,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int DW = CNT_W + DCT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              arm,
   input  logic              dct_valid,
   input  logic [DCT_W-1:0]  dct_buffer,
   input  logic [CNT_W-1:0]  dct_count,
   input  logic              test_ending,
   input  logic              test_has_ended,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [DW-1:0]     rd_data,
   output logic [ADDR_W:0]   fill_level,
   output logic [15:0]       drop_count,
   output logic              overflow,
   output logic              capturing,
   output logic              done
);
   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, FINISHED} state_t;
   state_t state;
   logic [DW-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic ended, full, wr_req, pop, drop, do_write, do_pop;
   assign full = fill_level == (ADDR_W+1)'(DEPTH);
   assign rd_valid = fill_level != '0;
   assign rd_data = mem[rd_ptr];
   assign capturing = state == CAPTURE;
   assign done = state == FINISHED;
   assign wr_req = !reset && !arm && capturing && dct_valid;
   assign pop = !reset && !arm && rd_valid && rd_ready;
   assign drop = wr_req && full && !pop;
   // ring mode turns a drop into "discard oldest": write proceeds and the read side advances
   assign do_write = wr_req && (!full || pop || OVERWRITE != 0);
   assign do_pop = pop || (drop && OVERWRITE != 0);
   always_ff @(posedge clk)
      if (do_write) mem[wr_ptr] <= {dct_count, dct_buffer};
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill_level <= '0;
         drop_count <= '0;
         overflow <= 1'b0;
         ended <= 1'b0;
      end else if (arm) begin
         state <= CAPTURE;
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill_level <= '0;
         drop_count <= '0;
         overflow <= 1'b0;
         ended <= 1'b0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         fill_level <= fill_level + (ADDR_W+1)'(do_write) - (ADDR_W+1)'(do_pop);
         if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
         if (drop) overflow <= 1'b1;
         if ((state == CAPTURE || state == DRAIN) && test_has_ended) ended <= 1'b1;
         state <= (state == CAPTURE && (test_ending || test_has_ended)) ? DRAIN :
                  (state == DRAIN && fill_level == '0 && (ended || test_has_ended)) ? FINISHED : state;
      end
   end
endmodule
